// File: rtl/riscv_sim_monitor.sv
// Test-completion monitor: classifies each hart as PASS/FAIL/HUNG from fetch PCs, captures a0,
// enforces a global cycle timeout and raises one registered verdict.
module riscv_sim_monitor #(
  parameter int NUM_HARTS   = 2,
  parameter int PC_W        = 32,
  parameter int CNT_W       = 16,
  parameter int STALL_LIMIT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable_i,
  input  logic [PC_W-1:0]         pass_pc_i,
  input  logic [PC_W-1:0]         fail_pc_i,
  input  logic [CNT_W-1:0]        timeout_i,
  input  logic [NUM_HARTS-1:0]    fetch_valid_i,
  input  logic [NUM_HARTS*PC_W-1:0] fetch_pc_i,
  input  logic [NUM_HARTS-1:0]    wb_valid_i,
  input  logic [NUM_HARTS*5-1:0]  wb_idx_i,
  input  logic [NUM_HARTS*32-1:0] wb_value_i,
  output logic [NUM_HARTS*2-1:0]  hart_status_o,
  output logic [NUM_HARTS*32-1:0] result_o,
  output logic [CNT_W-1:0]        cycle_count_o,
  output logic                    done_o,
  output logic                    pass_o,
  output logic                    timeout_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_PASS = 2'd1;
  localparam logic [1:0] ST_FAIL = 2'd2;
  localparam logic [1:0] ST_HUNG = 2'd3;

  localparam int REP_W = (STALL_LIMIT > 2) ? $clog2(STALL_LIMIT) : 1;
  localparam logic [REP_W-1:0] REP_HUNG = REP_W'(STALL_LIMIT - 2);

  logic [1:0]                       state;
  logic [CNT_W-1:0]                 cnt_q;
  logic [NUM_HARTS-1:0][1:0]        status_q, status_d;
  logic [NUM_HARTS-1:0][PC_W-1:0]   last_pc_q, last_pc_d;
  logic [NUM_HARTS-1:0][REP_W-1:0]  rep_q, rep_d;
  logic [NUM_HARTS-1:0][31:0]       a0_q, a0_d;

  logic [NUM_HARTS-1:0][PC_W-1:0]   pc_w;
  logic [NUM_HARTS-1:0][4:0]        idx_w;
  logic [NUM_HARTS-1:0][31:0]       val_w;

  logic all_term, all_pass, any_run_nxt, timeout_hit;

  assign pc_w  = fetch_pc_i;
  assign idx_w = wb_idx_i;
  assign val_w = wb_value_i;

  always_comb begin
    status_d  = status_q;
    last_pc_d = last_pc_q;
    rep_d     = rep_q;
    a0_d      = a0_q;
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (state == S_RUN && status_q[h] == ST_RUN) begin
        if (fetch_valid_i[h]) begin
          if (pc_w[h] == fail_pc_i) begin
            status_d[h] = ST_FAIL;
          end else if (pc_w[h] == pass_pc_i) begin
            status_d[h] = ST_PASS;
          end else if (pc_w[h] == last_pc_q[h]) begin
            rep_d[h] = rep_q[h] + 1'b1;
            // STALL_LIMIT-th identical fetch: count reaches STALL_LIMIT-1
            if (rep_q[h] == REP_HUNG) status_d[h] = ST_HUNG;
          end else begin
            last_pc_d[h] = pc_w[h];
            rep_d[h]     = '0;
          end
        end
        if (wb_valid_i[h] && idx_w[h] == 5'd10) a0_d[h] = val_w[h];
      end
    end
  end

  always_comb begin
    all_term    = 1'b1;
    all_pass    = 1'b1;
    any_run_nxt = 1'b0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (status_q[h] == ST_RUN)  all_term = 1'b0;
      if (status_q[h] != ST_PASS) all_pass = 1'b0;
      if (status_d[h] == ST_RUN)  any_run_nxt = 1'b1;
    end
  end

  // A hart terminating on the timeout cycle suppresses the timeout so completion is reported
  assign timeout_hit = (timeout_i != '0) && (cnt_q == timeout_i - CNT_W'(1)) && any_run_nxt;

  always_ff @(posedge clk) begin
    if (!rst || !enable_i) begin
      state     <= S_IDLE;
      cnt_q     <= '0;
      status_q  <= '0;
      last_pc_q <= '0;
      rep_q     <= '0;
      a0_q      <= '0;
      done_o    <= 1'b0;
      pass_o    <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state     <= S_RUN;
          cnt_q     <= '0;
          status_q  <= '0;
          last_pc_q <= '0;
          rep_q     <= '0;
          a0_q      <= '0;
        end
        S_RUN: begin
          status_q  <= status_d;
          last_pc_q <= last_pc_d;
          rep_q     <= rep_d;
          a0_q      <= a0_d;
          if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + CNT_W'(1);
          if (all_term) begin
            state  <= S_DONE;
            done_o <= 1'b1;
            pass_o <= all_pass;
          end else if (timeout_hit) begin
            state     <= S_DONE;
            done_o    <= 1'b1;
            timeout_o <= 1'b1;
          end
        end
        default: state <= S_DONE;
      endcase
    end
  end

  assign hart_status_o = status_q;
  assign result_o      = a0_q;
  assign cycle_count_o = cnt_q;

endmodule

// File: tb/tb_riscv_sim_monitor.sv
// Directed bench for riscv_sim_monitor: per-cycle vector table plus timeout/abort/reset sequences.
module tb_riscv_sim_monitor;

  localparam logic [31:0] PASS_PC = 32'h8000012c;
  localparam logic [31:0] FAIL_PC = 32'h80000130;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable_i;
  logic [31:0] pass_pc_i, fail_pc_i;
  logic [15:0] timeout_i;
  logic [1:0]  fetch_valid_i;
  logic [63:0] fetch_pc_i;
  logic [1:0]  wb_valid_i;
  logic [9:0]  wb_idx_i;
  logic [63:0] wb_value_i;
  logic [3:0]  hart_status_o;
  logic [63:0] result_o;
  logic [15:0] cycle_count_o;
  logic        done_o, pass_o, timeout_o;

  riscv_sim_monitor #(.NUM_HARTS(2), .PC_W(32), .CNT_W(16), .STALL_LIMIT(8)) dut (
    .clk(clk), .rst(rst), .enable_i(enable_i),
    .pass_pc_i(pass_pc_i), .fail_pc_i(fail_pc_i), .timeout_i(timeout_i),
    .fetch_valid_i(fetch_valid_i), .fetch_pc_i(fetch_pc_i),
    .wb_valid_i(wb_valid_i), .wb_idx_i(wb_idx_i), .wb_value_i(wb_value_i),
    .hart_status_o(hart_status_o), .result_o(result_o), .cycle_count_o(cycle_count_o),
    .done_o(done_o), .pass_o(pass_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [1:0]  fv;
    logic [31:0] pc0, pc1;
    logic [1:0]  wbv;
    logic [4:0]  idx0;
    logic [31:0] val0;
    logic [3:0]  st;
    logic        done, pass, tmo;
    logic [31:0] res0;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic add(input logic en, input logic [1:0] fv, input logic [31:0] pc0, input logic [31:0] pc1,
                     input logic [1:0] wbv, input logic [4:0] idx0, input logic [31:0] val0,
                     input logic [3:0] st, input logic done, input logic pass, input logic tmo,
                     input logic [31:0] res0, input logic [15:0] cnt);
    vec_t v;
    v.en = en; v.fv = fv; v.pc0 = pc0; v.pc1 = pc1; v.wbv = wbv; v.idx0 = idx0; v.val0 = val0;
    v.st = st; v.done = done; v.pass = pass; v.tmo = tmo; v.res0 = res0; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    fetch_valid_i = '0;
    fetch_pc_i    = '0;
    wb_valid_i    = '0;
    wb_idx_i      = '0;
    wb_value_i    = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] st, input logic done, input logic pass,
                         input logic tmo, input logic [31:0] res0, input logic [15:0] cnt);
    chk({tag, ".status"}, 64'(hart_status_o), 64'(st));
    chk({tag, ".done"},   64'(done_o),        64'(done));
    chk({tag, ".pass"},   64'(pass_o),        64'(pass));
    chk({tag, ".tmo"},    64'(timeout_o),     64'(tmo));
    chk({tag, ".res0"},   64'(result_o[31:0]), 64'(res0));
    chk({tag, ".cnt"},    64'(cycle_count_o), 64'(cnt));
  endtask

  initial begin
    // Run A: hart0 passes with a0 capture, hart1 fails
    add(1, 2'b00, 0, 0, 2'b00, 0, 0, 4'b0000, 0, 0, 0, 0, 0);
    add(1, 2'b01, 32'h80000000, 0, 2'b01, 10, 7, 4'b0000, 0, 0, 0, 7, 1);
    add(1, 2'b01, 32'h80000004, 0, 2'b00, 0, 0, 4'b0000, 0, 0, 0, 7, 2);
    add(1, 2'b11, PASS_PC, FAIL_PC, 2'b01, 10, 63, 4'b1001, 0, 0, 0, 63, 3);
    add(1, 2'b00, 0, 0, 2'b01, 10, 5, 4'b1001, 1, 0, 0, 63, 4);
    add(1, 2'b11, PASS_PC, PASS_PC, 2'b01, 12, 99, 4'b1001, 1, 0, 0, 63, 4);
    add(0, 2'b00, 0, 0, 2'b00, 0, 0, 4'b0000, 0, 0, 0, 0, 0);
    // Run B: both harts pass, x0 writeback ignored
    add(1, 2'b00, 0, 0, 2'b00, 0, 0, 4'b0000, 0, 0, 0, 0, 0);
    add(1, 2'b11, PASS_PC, PASS_PC, 2'b01, 0, 77, 4'b0101, 0, 0, 0, 0, 1);
    add(1, 2'b00, 0, 0, 2'b00, 0, 0, 4'b0101, 1, 1, 0, 0, 2);
    add(1, 2'b00, 0, 0, 2'b00, 0, 0, 4'b0101, 1, 1, 0, 0, 2);
    add(0, 2'b00, 0, 0, 2'b00, 0, 0, 4'b0000, 0, 0, 0, 0, 0);
    // Run C: hart0 hangs on the 8th identical fetch; hart1 repeats 7 times then moves on
    add(1, 2'b00, 0, 0, 2'b00, 0, 0, 4'b0000, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 7; i++)
      add(1, 2'b11, 32'h80000020, 32'h80000040, 2'b00, 0, 0, 4'b0000, 0, 0, 0, 0, 16'(i));
    add(1, 2'b11, 32'h80000020, 32'h80000044, 2'b00, 0, 0, 4'b0011, 0, 0, 0, 0, 8);
    add(1, 2'b10, 0, PASS_PC, 2'b00, 0, 0, 4'b0111, 0, 0, 0, 0, 9);
    add(1, 2'b00, 0, 0, 2'b00, 0, 0, 4'b0111, 1, 0, 0, 0, 10);
    add(0, 2'b00, 0, 0, 2'b00, 0, 0, 4'b0000, 0, 0, 0, 0, 0);

    rst = 1'b0; enable_i = 1'b0; timeout_i = '0;
    pass_pc_i = PASS_PC; fail_pc_i = FAIL_PC;
    idle_inputs();
    step(); step();
    chk_all("reset", 4'b0000, 0, 0, 0, 0, 0);
    rst = 1'b1;
    step();

    foreach (vecs[i]) begin
      enable_i      = vecs[i].en;
      fetch_valid_i = vecs[i].fv;
      fetch_pc_i    = {vecs[i].pc1, vecs[i].pc0};
      wb_valid_i    = vecs[i].wbv;
      wb_idx_i      = {5'd0, vecs[i].idx0};
      wb_value_i    = {32'd0, vecs[i].val0};
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].done, vecs[i].pass, vecs[i].tmo,
              vecs[i].res0, vecs[i].cnt);
    end
    idle_inputs();

    // Timeout of 100 cycles with no terminating fetches
    begin
      bit seen = 1'b0;
      timeout_i = 16'd100;
      enable_i  = 1'b1;
      for (int c = 0; c < 300; c++) begin
        step();
        if (done_o) begin seen = 1'b1; break; end
      end
      chk("tmo.seen", 64'(seen), 64'd1);
      chk_all("tmo", 4'b0000, 1, 0, 1, 0, 16'd100);
      step();
      chk_all("tmo.hold", 4'b0000, 1, 0, 1, 0, 16'd100);
    end

    // Timeout disabled: counter saturates, no verdict
    enable_i = 1'b0; step();
    timeout_i = '0;
    enable_i  = 1'b1;
    for (int c = 0; c < 65540; c++) @(posedge clk);
    #1;
    chk("sat.cnt",  64'(cycle_count_o), 64'hFFFF);
    chk("sat.done", 64'(done_o), 64'd0);

    // Abort by dropping enable after 10 RUN cycles
    enable_i = 1'b0; step();
    enable_i = 1'b1; step();
    wb_valid_i = 2'b01; wb_idx_i = 10'd10; wb_value_i = 64'd9;
    step();
    idle_inputs();
    for (int c = 0; c < 9; c++) step();
    chk_all("abort.pre", 4'b0000, 0, 0, 0, 9, 16'd10);
    enable_i = 1'b0; step();
    chk_all("abort", 4'b0000, 0, 0, 0, 0, 0);

    // Last hart terminates on the timeout cycle: completion wins
    timeout_i = 16'd5;
    enable_i  = 1'b1; step();
    for (int c = 0; c < 4; c++) step();
    chk("tie.cnt4", 64'(cycle_count_o), 64'd4);
    fetch_valid_i = 2'b11; fetch_pc_i = {PASS_PC, PASS_PC};
    step();
    idle_inputs();
    chk_all("tie.term", 4'b0101, 0, 0, 0, 0, 16'd5);
    step();
    chk_all("tie.done", 4'b0101, 1, 1, 0, 0, 16'd6);

    // Reset asserted while in DONE
    rst = 1'b0; step();
    chk_all("rst.done", 4'b0000, 0, 0, 0, 0, 0);
    rst = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_sim_monitor.md
Name: riscv_sim_monitor

Overview:
Synthesizable test-completion monitor for multi-hart biRISC-V simulation and FPGA self-test builds. It watches per-hart fetch PCs and register writebacks and classifies each hart as PASS, FAIL or HUNG. It also enforces a global cycle timeout, captures each hart's a0 (x10) at termination, and raises a single registered verdict. It sits beside the core(s) and TCM and is driven from fetch/writeback taps.

Parameters:
NUM_HARTS, 2, number of monitored harts (1..8)
PC_W, 32, fetch PC width
CNT_W, 16, cycle counter / timeout width
STALL_LIMIT, 8, consecutive same-PC fetches that declare a hart HUNG (>=2)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
enable_i  in  1  start/hold monitoring; low aborts to IDLE
pass_pc_i  in  PC_W  pass-loop address
fail_pc_i  in  PC_W  fail-loop address
timeout_i  in  CNT_W  timeout in cycles; 0 disables
fetch_valid_i  in  NUM_HARTS  per-hart fetch accepted strobe
fetch_pc_i  in  NUM_HARTS*PC_W  per-hart fetch PC, hart h at [h*PC_W +: PC_W]
wb_valid_i  in  NUM_HARTS  per-hart integer writeback strobe
wb_idx_i  in  NUM_HARTS*5  writeback register index
wb_value_i  in  NUM_HARTS*32  writeback value
hart_status_o  out  NUM_HARTS*2  per-hart status: 0 RUN, 1 PASS, 2 FAIL, 3 HUNG
result_o  out  NUM_HARTS*32  per-hart a0, frozen once the hart is terminal
cycle_count_o  out  CNT_W  cycles spent in RUN, saturating
done_o  out  1  verdict valid (sticky)
pass_o  out  1  all harts PASS and no timeout
timeout_o  out  1  timeout ended the run

Behaviour:
- Reset (rst==0 at posedge): global state IDLE. All outputs 0, all per-hart status RUN(0), last_pc 0, repeat counters 0, a0 shadows 0.
- Global FSM: IDLE -> RUN when enable_i=1. Any state -> IDLE when enable_i=0.
  - Entering RUN clears cycle_count, statuses, repeat counters and shadows.
  - RUN -> DONE per the rules below. DONE holds until enable_i=0 or reset.
- IDLE: no fetch or writeback event is processed.
- cycle_count: increments every RUN cycle and saturates at all-ones. It is frozen in DONE and cleared in IDLE.
- Per-hart fetch event (RUN, status==RUN, fetch_valid_i[h]=1), evaluated in priority order:
  1. pc==fail_pc_i -> FAIL.
  2. pc==pass_pc_i -> PASS. FAIL wins if pass_pc_i==fail_pc_i.
  3. pc==last_pc[h] -> repeat count +1. When the count reaches STALL_LIMIT-1 (i.e. the STALL_LIMIT-th identical fetch), status becomes HUNG.
  4. Otherwise: last_pc[h]=pc, repeat count 0.
  - Status updates are visible on hart_status_o the cycle after the fetch.
- Fetch strobes are ignored for harts already terminal. Terminal statuses are sticky within a run.
- Writeback: in RUN with status==RUN, wb_valid_i[h]=1 and wb_idx_i==10 loads the shadow from wb_value_i. Writes to x0 and other indices are ignored.
- result_o[h] tracks the shadow while the hart is RUN and freezes when the hart turns terminal.
  - A writeback in the same cycle as the terminating fetch is included in the frozen value.
- Completion: done_o rises the cycle after the last hart's status becomes terminal (two cycles after that hart's terminating fetch).
  - pass_o = all PASS. timeout_o = 0.
- Timeout: if timeout_i!=0 and cycle_count==timeout_i-1 while any hart is RUN, the next cycle is DONE with timeout_o=1 and pass_o=0.
  - Harts still RUN remain RUN.
  - If the last hart terminates in the same cycle the timeout is hit, completion wins (timeout_o=0).
- done_o, pass_o and timeout_o are registered and stable throughout DONE. All change only on clk.
- enable_i low mid-run: next cycle IDLE, done_o=0, no verdict.

Test Plan:
- NUM_HARTS=1, pass_pc=0x8000012c, fail_pc=0x80000130; fetch 0x80000000, 0x80000004, 0x8000012c -> status 1 one cycle later, done_o=1 and pass_o=1 the cycle after, timeout_o=0.
- NUM_HARTS=2: hart0 reaches pass, hart1 reaches 0x80000130 -> status {2,1}; done_o=1, pass_o=0.
- Hart0 writeback x10=63 with its pass fetch in the same cycle, then x10=5 -> result_o[0]=63 frozen. Writeback x12=99 does not change result_o.
- STALL_LIMIT=8: hart fetches 0x80000020 eight consecutive times -> HUNG (3) after the 8th. Seven repeats then 0x80000024 -> still RUN.
- timeout_i=100, no pass/fail fetches -> done_o and timeout_o rise with cycle_count_o=100, pass_o=0. timeout_i=0 -> never done, cycle_count saturates at 0xFFFF.
- enable_i dropped at cycle 10 of RUN -> IDLE next cycle, outputs cleared. rst low mid-DONE -> all outputs 0 next cycle.
